// File: rtl/axi4lite_cfg_bridge.sv
// AXI4-Lite slave bridging register accesses onto a single-cycle cfg bus.
// Write and read paths are independent FSMs; every output is registered.
module axi4lite_cfg_bridge #(
    parameter int AXI_WIDTH  = 32,
    parameter int AXI_AWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter int CFG_DEPTH  = 2 ** CFG_AWIDTH,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [AXI_WIDTH-1:0]    cfg_wr_data,
    output logic [AXI_WIDTH/8-1:0]  cfg_wr_strb,
    output logic [CFG_AWIDTH-1:0]   cfg_wr_addr,
    output logic                    cfg_wr_en,
    input  logic [AXI_WIDTH-1:0]    cfg_rd_data,
    output logic [CFG_AWIDTH-1:0]   cfg_rd_addr,
    output logic                    cfg_rd_en,
    input  logic [AXI_AWIDTH-1:0]   axi_awaddr,
    input  logic [2:0]              axi_awprot,
    input  logic                    axi_awvalid,
    output logic                    axi_awready,
    input  logic [AXI_WIDTH-1:0]    axi_wdata,
    input  logic [AXI_WIDTH/8-1:0]  axi_wstrb,
    input  logic                    axi_wvalid,
    output logic                    axi_wready,
    output logic [1:0]              axi_bresp,
    output logic                    axi_bvalid,
    input  logic                    axi_bready,
    input  logic [AXI_AWIDTH-1:0]   axi_araddr,
    input  logic [2:0]              axi_arprot,
    input  logic                    axi_arvalid,
    output logic                    axi_arready,
    output logic [AXI_WIDTH-1:0]    axi_rdata,
    output logic [1:0]              axi_rresp,
    output logic                    axi_rvalid,
    input  logic                    axi_rready
);

    localparam int SW  = AXI_WIDTH / 8;
    localparam int LSB = $clog2(SW);
    localparam logic [CFG_AWIDTH:0] DEPTH = (CFG_AWIDTH + 1)'(CFG_DEPTH);
    localparam logic [2:0] LAST = 3'(RD_LATENCY - 1);

    typedef enum logic [1:0] {W_COLLECT, W_ISSUE, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

    w_state_t w_state;
    r_state_t r_state;

    logic                  aw_held;
    logic                  w_held;
    logic [CFG_AWIDTH-1:0] aw_idx;
    logic [AXI_WIDTH-1:0]  wdata_q;
    logic [SW-1:0]         wstrb_q;
    logic                  ar_oor;
    logic [2:0]            rd_cnt;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  aw_have;
    logic                  w_have;
    logic [CFG_AWIDTH-1:0] wr_idx;
    logic [AXI_WIDTH-1:0]  wr_data;
    logic [SW-1:0]         wr_strb;
    logic                  wr_oor;
    logic [CFG_AWIDTH-1:0] rd_idx;
    logic                  rd_oor;
    logic                  unused_addr_bits;

    // Only the register index is decoded; base, byte offset and prot are dropped.
    assign unused_addr_bits = ^{axi_awaddr, axi_araddr, axi_awprot, axi_arprot};

    always_comb begin
        aw_hs   = axi_awvalid && axi_awready;
        w_hs    = axi_wvalid && axi_wready;
        ar_hs   = axi_arvalid && axi_arready;
        aw_have = aw_held || aw_hs;
        w_have  = w_held || w_hs;
        wr_idx  = aw_held ? aw_idx : axi_awaddr[LSB +: CFG_AWIDTH];
        wr_data = w_held ? wdata_q : axi_wdata;
        wr_strb = w_held ? wstrb_q : axi_wstrb;
        wr_oor  = {1'b0, wr_idx} >= DEPTH;
        rd_idx  = axi_araddr[LSB +: CFG_AWIDTH];
        rd_oor  = {1'b0, rd_idx} >= DEPTH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state     <= W_COLLECT;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            aw_idx      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            axi_awready <= 1'b0;
            axi_wready  <= 1'b0;
            axi_bvalid  <= 1'b0;
            axi_bresp   <= 2'b00;
            cfg_wr_en   <= 1'b0;
            cfg_wr_addr <= '0;
            cfg_wr_data <= '0;
            cfg_wr_strb <= '0;
        end else begin
            cfg_wr_en <= 1'b0;
            unique case (w_state)
                W_COLLECT: begin
                    if (aw_hs) begin
                        aw_held <= 1'b1;
                        aw_idx  <= axi_awaddr[LSB +: CFG_AWIDTH];
                    end
                    if (w_hs) begin
                        w_held  <= 1'b1;
                        wdata_q <= axi_wdata;
                        wstrb_q <= axi_wstrb;
                    end
                    if (aw_have && w_have) begin
                        aw_held     <= 1'b0;
                        w_held      <= 1'b0;
                        axi_awready <= 1'b0;
                        axi_wready  <= 1'b0;
                        cfg_wr_en   <= !wr_oor && (|wr_strb);
                        cfg_wr_addr <= wr_idx;
                        cfg_wr_data <= wr_data;
                        cfg_wr_strb <= wr_strb;
                        axi_bvalid  <= 1'b1;
                        axi_bresp   <= wr_oor ? 2'b10 : 2'b00;
                        w_state     <= W_ISSUE;
                    end else begin
                        axi_awready <= !aw_have;
                        axi_wready  <= !w_have;
                    end
                end
                // bvalid is already visible in W_ISSUE, so a B handshake counts there too.
                W_ISSUE, W_RESP: begin
                    if (axi_bready) begin
                        axi_bvalid  <= 1'b0;
                        axi_bresp   <= 2'b00;
                        axi_awready <= 1'b1;
                        axi_wready  <= 1'b1;
                        w_state     <= W_COLLECT;
                    end else begin
                        w_state <= W_RESP;
                    end
                end
                default: w_state <= W_COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= R_IDLE;
            ar_oor      <= 1'b0;
            rd_cnt      <= '0;
            axi_arready <= 1'b0;
            axi_rvalid  <= 1'b0;
            axi_rresp   <= 2'b00;
            axi_rdata   <= '0;
            cfg_rd_en   <= 1'b0;
            cfg_rd_addr <= '0;
        end else begin
            cfg_rd_en <= 1'b0;
            unique case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        axi_arready <= 1'b0;
                        ar_oor      <= rd_oor;
                        cfg_rd_en   <= !rd_oor;
                        cfg_rd_addr <= rd_idx;
                        rd_cnt      <= '0;
                        r_state     <= R_WAIT;
                    end else begin
                        axi_arready <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (rd_cnt == LAST) begin
                        axi_rdata  <= ar_oor ? '0 : cfg_rd_data;
                        axi_rresp  <= ar_oor ? 2'b10 : 2'b00;
                        axi_rvalid <= 1'b1;
                        r_state    <= R_RESP;
                    end else begin
                        rd_cnt <= rd_cnt + 3'd1;
                    end
                end
                R_RESP: begin
                    if (axi_rready) begin
                        axi_rvalid  <= 1'b0;
                        axi_rresp   <= 2'b00;
                        axi_arready <= 1'b1;
                        r_state     <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule
